bank_addr_xbar: RTL and testbench
=================================

BANK_ADDR_XBAR -- requirements
Module: bank_addr_xbar

Interface
REQ-001 Parameter ADDR_WIDTH, default 6: width of one bank address.
REQ-002 Parameter LANES, default 16: number of lanes; a power of two, 2..64.
REQ-003 Localparam SEL_WIDTH = log2(LANES): width of one lane select.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 cfg_we  input  1  loads the select pattern when high.
REQ-007 cfg_sel  input  LANES*SEL_WIDTH  select pattern; lane i occupies bits [i*SEL_WIDTH +: SEL_WIDTH].
REQ-008 in_valid  input  1  input beat valid.
REQ-009 in_ready  output  1  block can accept a beat.
REQ-010 in_addr  input  LANES*ADDR_WIDTH  input addresses; lane j occupies bits [j*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 out_valid  output  1  output beat valid.
REQ-012 out_ready  input  1  downstream accepts the output beat.
REQ-013 out_addr  output  LANES*ADDR_WIDTH  permuted addresses.
REQ-014 out_err  output  1  the current output beat was produced with a non-permutation pattern.
REQ-015 err_cnt  output  8  count of output beats that had out_err set; saturating.

Function
REQ-016 Pattern register cfg_q: cfg_we=1 loads cfg_sel at the clock edge, and cfg_q holds its value otherwise.
REQ-017 Accept: a beat is accepted on an edge where in_valid && in_ready.
  - An accepted beat captures in_addr and a snapshot of cfg_q into stage 1 (s1).
  - cfg_we in the same cycle does not affect that beat; the new pattern applies from the next accepted beat.
REQ-018 Stage 1 advance: adv1 = s1_valid && (!out_valid || out_ready).
REQ-019 in_ready = !s1_valid || adv1, combinational, with no dependence on in_valid.
REQ-020 On adv1, the output stage registers out_addr lane i = s1 addr lane (s1 sel lane i), for every i.
REQ-021 On adv1, out_err is also registered: 1 when any two lanes of the s1 sel snapshot are equal, else 0. Every pair is compared.
REQ-022 s1_valid update each edge:
  - set on accept;
  - cleared on adv1 without a new accept;
  - held otherwise.
REQ-023 out_valid update each edge:
  - set on adv1;
  - cleared on out_ready without adv1;
  - held otherwise.
REQ-024 While out_valid && !out_ready, out_addr and out_err hold stable; no beat is lost or duplicated.
REQ-025 Latency: a beat accepted at edge k presents out_valid=1 after edge k+1. Throughput is 1 beat/cycle while out_ready=1.
REQ-026 err_cnt increments by 1 on each output handshake (out_valid && out_ready) with out_err=1, and saturates at 255.
REQ-027 Duplicate selects are not blocked: data is still routed per REQ-020 and is only flagged by REQ-021.

Reset
REQ-028 rst=1 asynchronously forces the following, with no partial beat emitted after release:
  - s1_valid=0, out_valid=0, out_err=0, err_cnt=0;
  - out_addr=0, s1 data=0;
  - cfg_q = identity (lane i selects i).
REQ-029 Reset asserted mid-stream discards all in-flight beats.
REQ-030 While rst=1, in_ready reads 1 and accepts are ignored. Operation resumes on the first edge after release.

Verification
REQ-031 Identity pattern after reset, lane j addr = j+32, out_ready=1:
  - out_addr lane i = i+32, two edges after accept;
  - out_err=0.
REQ-032 Reversal pattern (lane i selects 15-i), then a beat with lane j addr = j:
  - out lane 0 = 15, out lane 15 = 0;
  - out_err=0.
REQ-033 Pattern with lanes 0 and 1 both selecting 3:
  - out_err=1 and both lanes = in lane 3;
  - 300 such handshakes -> err_cnt = 255 and stays there.
REQ-034 Backpressure: 4 back-to-back beats with out_ready=0 for 5 cycles:
  - in_ready drops after 2 beats are accepted;
  - out_addr holds stable;
  - after out_ready=1, all 4 beats emerge in order, with none dropped or repeated.
REQ-035 cfg_we=1 with a reversal pattern in the same cycle as an accept:
  - that beat uses identity;
  - the next beat uses reversal.
REQ-036 rst pulsed while s1 and the output stage are both full:
  - out_valid=0 immediately and err_cnt=0;
  - the next beat after release emerges with identity routing.

Source files
------------

// File: rtl/bank_addr_xbar.sv
// bank_addr_xbar: two-stage lane crossbar for bank addresses.
// A per-lane select pattern routes input lanes to output lanes; duplicate selects are flagged.
module bank_addr_xbar #(
    parameter int ADDR_WIDTH = 6,
    parameter int LANES      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 cfg_we,
    input  logic [LANES*$clog2(LANES)-1:0]       cfg_sel,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [LANES*ADDR_WIDTH-1:0]          in_addr,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [LANES*ADDR_WIDTH-1:0]          out_addr,
    output logic                                 out_err,
    output logic [7:0]                           err_cnt
);

    localparam int SEL_WIDTH = $clog2(LANES);
    localparam int SEL_BITS  = LANES * SEL_WIDTH;
    localparam int ADR_BITS  = LANES * ADDR_WIDTH;

    // Pattern where every output lane selects its own input lane.
    function automatic logic [SEL_BITS-1:0] ident_fn();
        logic [SEL_BITS-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            v[i*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(i);
        end
        return v;
    endfunction

    localparam logic [SEL_BITS-1:0] IDENT_SEL = ident_fn();

    // Pattern register
    logic [SEL_BITS-1:0] cfg_q;
    logic [SEL_BITS-1:0] cfg_d;

    // Stage 1: captured addresses plus the pattern snapshot taken at accept
    logic                s1_valid_q;
    logic                s1_valid_d;
    logic [ADR_BITS-1:0] s1_addr_q;
    logic [ADR_BITS-1:0] s1_addr_d;
    logic [SEL_BITS-1:0] s1_sel_q;
    logic [SEL_BITS-1:0] s1_sel_d;

    // Output stage
    logic                out_valid_q;
    logic                out_valid_d;
    logic [ADR_BITS-1:0] out_addr_q;
    logic [ADR_BITS-1:0] out_addr_d;
    logic                out_err_q;
    logic                out_err_d;
    logic [7:0]          err_cnt_q;
    logic [7:0]          err_cnt_d;

    // Handshake terms
    logic                accept;
    logic                adv1;
    logic                out_hs;

    // Combinational results of the stage-1 snapshot
    logic [ADR_BITS-1:0] perm;
    logic                dup;

    assign adv1     = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || adv1;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    // Route each output lane from the input lane named by its select field
    always_comb begin
        perm = '0;
        for (int i = 0; i < LANES; i++) begin
            int sidx;
            sidx = int'(s1_sel_q[i*SEL_WIDTH +: SEL_WIDTH]);
            perm[i*ADDR_WIDTH +: ADDR_WIDTH] =
                s1_addr_q[sidx*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Flag the snapshot when any two lanes share a select value
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (s1_sel_q[i*SEL_WIDTH +: SEL_WIDTH] ==
                    s1_sel_q[j*SEL_WIDTH +: SEL_WIDTH]) begin
                    dup = 1'b1;
                end
            end
        end
    end

    // Next state for the pattern register and stage 1
    always_comb begin
        cfg_d      = cfg_q;
        s1_valid_d = s1_valid_q;
        s1_addr_d  = s1_addr_q;
        s1_sel_d   = s1_sel_q;
        if (cfg_we) begin
            cfg_d = cfg_sel;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_addr_d  = in_addr;
            s1_sel_d   = cfg_q;
        end else if (adv1) begin
            s1_valid_d = 1'b0;
        end
    end

    // Next state for the output stage and the saturating error counter
    always_comb begin
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;
        if (adv1) begin
            out_valid_d = 1'b1;
            out_addr_d  = perm;
            out_err_d   = dup;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (out_hs && out_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Pattern register; reset restores identity routing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q <= IDENT_SEL;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    // Stage 1 registers; reset discards any held beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            s1_sel_q   <= IDENT_SEL;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_addr_q  <= s1_addr_d;
            s1_sel_q   <= s1_sel_d;
        end
    end

    // Output stage registers and error counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_addr  = out_addr_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_bank_addr_xbar.sv
// tb_bank_addr_xbar: directed checks of the bank address crossbar.
// Routing, duplicate flagging, backpressure, pattern timing and reset.
module tb_bank_addr_xbar;

    localparam int AW = 6;
    localparam int L  = 16;
    localparam int SW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            cfg_we;
    logic [L*SW-1:0] cfg_sel;
    logic            in_valid;
    logic            in_ready;
    logic [L*AW-1:0] in_addr;
    logic            out_valid;
    logic            out_ready;
    logic [L*AW-1:0] out_addr;
    logic            out_err;
    logic [7:0]      err_cnt;

    int errors = 0;
    int checks = 0;

    bank_addr_xbar #(.ADDR_WIDTH(AW), .LANES(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [L*AW-1:0] mk_addr(input int base);
        logic [L*AW-1:0] v;
        v = '0;
        for (int j = 0; j < L; j++) v[j*AW +: AW] = AW'(base + j);
        return v;
    endfunction

    function automatic logic [L*SW-1:0] id_sel();
        logic [L*SW-1:0] v;
        v = '0;
        for (int i = 0; i < L; i++) v[i*SW +: SW] = SW'(i);
        return v;
    endfunction

    function automatic logic [L*SW-1:0] rev_sel();
        logic [L*SW-1:0] v;
        v = '0;
        for (int i = 0; i < L; i++) v[i*SW +: SW] = SW'(L - 1 - i);
        return v;
    endfunction

    function automatic logic [L*AW-1:0] permute(input logic [L*AW-1:0] a, input logic [L*SW-1:0] s);
        logic [L*AW-1:0] v;
        v = '0;
        for (int i = 0; i < L; i++) begin
            int k;
            k = int'(s[i*SW +: SW]);
            v[i*AW +: AW] = a[k*AW +: AW];
        end
        return v;
    endfunction

    logic [L*AW-1:0] bp [4];
    logic [L*AW-1:0] cap;
    logic [L*SW-1:0] dsel;
    logic            hs_in;
    logic            hs_out;
    int              nin;
    int              nout;

    initial begin
        rst       = 1'b1;
        cfg_we    = 1'b0;
        cfg_sel   = '0;
        in_valid  = 1'b1;
        in_addr   = mk_addr(10);
        out_ready = 1'b1;

        // Reset state, with accepts attempted while reset is high
        repeat (2) tick();
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_err_cnt", err_cnt, 8'd0);
        check("rst_out_addr", out_addr, '0);
        #2 rst = 1'b0;
        in_valid = 1'b0;
        tick();
        check("rst_no_beat", out_valid, 1'b0);

        // Identity routing, lane j = j+32, two-edge latency
        in_addr  = mk_addr(32);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("id_lat1", out_valid, 1'b0);
        tick();
        check("id_valid", out_valid, 1'b1);
        check("id_addr", out_addr, mk_addr(32));
        check("id_lane0", out_addr[5:0], 6'd32);
        check("id_err", out_err, 1'b0);
        tick();
        check("id_drain", out_valid, 1'b0);

        // Reversal pattern
        cfg_sel = rev_sel();
        cfg_we  = 1'b1;
        tick();
        cfg_we   = 1'b0;
        in_addr  = mk_addr(0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("rev_lane0", out_addr[5:0], 6'd15);
        check("rev_lane15", out_addr[95:90], 6'd0);
        check("rev_addr", out_addr, permute(mk_addr(0), rev_sel()));
        check("rev_err", out_err, 1'b0);
        tick();

        // Duplicate selects: lanes 0 and 1 both pick lane 3
        dsel        = id_sel();
        dsel[3:0]   = 4'd3;
        dsel[7:4]   = 4'd3;
        cfg_sel     = dsel;
        cfg_we      = 1'b1;
        tick();
        cfg_we   = 1'b0;
        in_addr  = mk_addr(32);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("dup_err", out_err, 1'b1);
        check("dup_lane0", out_addr[5:0], 6'd35);
        check("dup_lane1", out_addr[11:6], 6'd35);
        check("dup_lane2", out_addr[17:12], 6'd34);
        check("dup_cnt0", err_cnt, 8'd0);
        tick();
        check("dup_cnt1", err_cnt, 8'd1);
        in_valid = 1'b1;
        repeat (300) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("dup_sat", err_cnt, 8'd255);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("dup_sat_hold", err_cnt, 8'd255);

        // Backpressure: 4 beats, out_ready low for 5 cycles
        cfg_sel = id_sel();
        cfg_we  = 1'b1;
        tick();
        cfg_we = 1'b0;
        for (int b = 0; b < 4; b++) bp[b] = mk_addr(b * 8);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_addr   = bp[0];
        tick();
        check("bp_rdy1", in_ready, 1'b1);
        in_addr = bp[1];
        tick();
        check("bp_rdy2", in_ready, 1'b0);
        check("bp_out0", out_addr, bp[0]);
        nin     = 2;
        in_addr = bp[2];
        repeat (3) begin
            tick();
            check("bp_stall_rdy", in_ready, 1'b0);
            check("bp_hold", out_addr, bp[0]);
        end
        out_ready = 1'b1;
        nout      = 0;
        for (int c = 0; c < 20 && nout < 4; c++) begin
            in_valid = (nin < 4);
            in_addr  = (nin < 4) ? bp[nin] : '0;
            #1;
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            cap    = out_addr;
            @(posedge clk);
            #1;
            if (hs_out) begin
                check("bp_order", cap, bp[nout]);
                nout++;
            end
            if (hs_in) nin++;
        end
        in_valid = 1'b0;
        check("bp_count", nout, 4);
        check("bp_no_dup", out_valid, 1'b0);

        // Pattern written in the same cycle as an accept
        cfg_sel  = rev_sel();
        cfg_we   = 1'b1;
        in_addr  = mk_addr(0);
        in_valid = 1'b1;
        tick();
        cfg_we  = 1'b0;
        in_addr = mk_addr(16);
        tick();
        in_valid = 1'b0;
        check("cfg_old", out_addr, mk_addr(0));
        tick();
        check("cfg_new", out_addr, permute(mk_addr(16), rev_sel()));
        check("cfg_new_lane0", out_addr[5:0], 6'd31);
        tick();

        // Reset while both stages are full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_addr   = mk_addr(40);
        tick();
        in_addr = mk_addr(20);
        tick();
        in_valid = 1'b0;
        check("full_valid", out_valid, 1'b1);
        check("full_rdy", in_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_cnt", err_cnt, 8'd0);
        check("mid_rst_rdy", in_ready, 1'b1);
        in_valid = 1'b1;
        in_addr  = mk_addr(1);
        @(posedge clk);
        #2;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("post_rst_empty", out_valid, 1'b0);
        in_addr  = mk_addr(32);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("post_rst_valid", out_valid, 1'b1);
        check("post_rst_id", out_addr, mk_addr(32));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
